mem_port_arbiter: RTL and testbench

//   Shares one single-port unified instruction/data memory between the IF-stage fetch and the
//   MEM-stage load/store (lw/lb/sw/sb) of the 5-stage MIPS pipeline.

---
 rtl/mem_port_arbiter_if.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module  : mem_port_arbiter_if
// Brief   : Bundles the fetch, data and memory-side signals of the
//           unified-memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction fetch port
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_valid;
  // Data load/store port
  logic                  dm_req;
  logic                  dm_we;
  logic [DATA_W/8-1:0]   dm_be;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_valid;
  // Shared memory port
  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  // Pipeline stall outputs
  logic                  stall_if;
  logic                  stall_mem;

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_valid,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_rdata, dm_valid,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata,
    output stall_if, stall_mem
  );

  // Pipeline/memory side
  modport master (
    output if_req, if_addr,
    input  if_rdata, if_valid,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_rdata, dm_valid,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata,
    input  stall_if, stall_mem
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one single-port unified memory between IF fetch and MEM
//           load/store. Data side has fixed priority; IF is forced through
//           once after STARVE_MAX consecutive losses. One access in flight.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] c_WAIT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'(1);
  localparam logic [STV_W-1:0] c_STV_MAX   = STV_W'(STARVE_MAX);
  localparam logic [STV_W-1:0] c_STV_ONE   = STV_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_owner_dm;   // 1 = data port owns the access
  logic [STV_W-1:0]    r_starve;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [BE_W-1:0]     r_mem_be;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_if_valid;
  logic                r_dm_valid;

  logic                w_any_req;
  logic                w_if_wins;

  assign w_any_req = bus.if_req | bus.dm_req;
  // IF takes the port when it is alone or when it has lost too often in a row.
  assign w_if_wins = bus.if_req & (~bus.dm_req | (r_starve == c_STV_MAX));

  // Access sequencer: arbitration, memory strobe, wait counting and response pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner_dm  <= 1'b0;
      r_starve    <= '0;
      r_wait_cnt  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
    end else begin
      // Strobes and completion pulses are single-cycle unless set below.
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_mem_en <= 1'b1;
            r_state  <= S_ISSUE;
            if (w_if_wins) begin
              r_owner_dm  <= 1'b0;
              r_mem_we    <= 1'b0;
              r_mem_be    <= '1;
              r_mem_addr  <= bus.if_addr;
              r_mem_wdata <= '0;
              r_starve    <= '0;
            end else begin
              r_owner_dm  <= 1'b1;
              r_mem_we    <= bus.dm_we;
              r_mem_be    <= bus.dm_be;
              r_mem_addr  <= bus.dm_addr;
              r_mem_wdata <= bus.dm_wdata;
              // A store completes in the same cycle it is issued.
              r_dm_valid  <= bus.dm_we;
              if (bus.if_req && (r_starve != c_STV_MAX)) begin
                r_starve <= r_starve + c_STV_ONE;
              end
            end
          end
        end
        S_ISSUE: begin
          if (r_mem_we) begin
            r_state <= S_IDLE;
          end else if (MEM_LAT == 1) begin
            r_state    <= S_RESP;
            r_if_valid <= ~r_owner_dm;
            r_dm_valid <= r_owner_dm;
          end else begin
            r_state    <= S_WAIT;
            r_wait_cnt <= c_WAIT_INIT;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - c_WAIT_LAST;
          if (r_wait_cnt == c_WAIT_LAST) begin
            r_state    <= S_RESP;
            r_if_valid <= ~r_owner_dm;
            r_dm_valid <= r_owner_dm;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

  // Read data is a straight pass-through; only meaningful while valid.
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.dm_valid  = r_dm_valid;

  assign bus.stall_if  = bus.if_req & ~r_if_valid;
  assign bus.stall_mem = bus.dm_req & ~r_dm_valid;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed self-checking bench for mem_port_arbiter with
//           MEM_LAT = 2 (main), 1 and 4 instances.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   n_cnt;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ia ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ib ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ic ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4))
    u_a (.clk(clk), .rst(rst), .bus(ia));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4))
    u_b (.clk(clk), .rst(rst), .bus(ib));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4), .STARVE_MAX(4))
    u_c (.clk(clk), .rst(rst), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    ia.if_req = 0; ia.if_addr = 0; ia.dm_req = 0; ia.dm_we = 0; ia.dm_be = 0;
    ia.dm_addr = 0; ia.dm_wdata = 0; ia.mem_rdata = 0;
    ib.if_req = 0; ib.if_addr = 0; ib.dm_req = 0; ib.dm_we = 0; ib.dm_be = 0;
    ib.dm_addr = 0; ib.dm_wdata = 0; ib.mem_rdata = 0;
    ic.if_req = 0; ic.if_addr = 0; ic.dm_req = 0; ic.dm_we = 0; ic.dm_be = 0;
    ic.dm_addr = 0; ic.dm_wdata = 0; ic.mem_rdata = 0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en",    32'(ia.mem_en),   32'd0);
    chk("rst_mem_we",    32'(ia.mem_we),   32'd0);
    chk("rst_if_valid",  32'(ia.if_valid), 32'd0);
    chk("rst_dm_valid",  32'(ia.dm_valid), 32'd0);
    chk("rst_mem_be",    32'(ia.mem_be),   32'd0);
    chk("rst_mem_addr",  ia.mem_addr,      32'd0);
    chk("rst_mem_wdata", ia.mem_wdata,     32'd0);
    cyc();
    rst = 1'b0;

    // ---------------- 1: IF-only fetch ----------------
    ia.if_req = 1; ia.if_addr = 32'h40;
    @(negedge clk);
    chk("t1_stall_c0", 32'(ia.stall_if), 32'd1);
    chk("t1_en_c0",    32'(ia.mem_en),   32'd0);
    cyc(); @(negedge clk);
    chk("t1_en_c1",    32'(ia.mem_en),   32'd1);
    chk("t1_addr_c1",  ia.mem_addr,      32'h40);
    chk("t1_be_c1",    32'(ia.mem_be),   32'hF);
    chk("t1_we_c1",    32'(ia.mem_we),   32'd0);
    chk("t1_stall_c1", 32'(ia.stall_if), 32'd1);
    cyc(); ia.mem_rdata = 32'h8C080004; @(negedge clk);
    chk("t1_en_c2",    32'(ia.mem_en),   32'd0);
    chk("t1_valid_c2", 32'(ia.if_valid), 32'd0);
    chk("t1_stall_c2", 32'(ia.stall_if), 32'd1);
    cyc(); @(negedge clk);
    chk("t1_valid_c3", 32'(ia.if_valid), 32'd1);
    chk("t1_rdata_c3", ia.if_rdata,      32'h8C080004);
    chk("t1_stall_c3", 32'(ia.stall_if), 32'd0);
    chk("t1_dmv_c3",   32'(ia.dm_valid), 32'd0);
    ia.if_req = 0;
    cyc();

    // ---------------- 3: store word ----------------
    ia.dm_req = 1; ia.dm_we = 1; ia.dm_be = 4'hF;
    ia.dm_addr = 32'h200; ia.dm_wdata = 32'h1234ABCD;
    cyc(); @(negedge clk);
    chk("t3_en_c1",    32'(ia.mem_en),    32'd1);
    chk("t3_we_c1",    32'(ia.mem_we),    32'd1);
    chk("t3_addr_c1",  ia.mem_addr,       32'h200);
    chk("t3_wdata_c1", ia.mem_wdata,      32'h1234ABCD);
    chk("t3_valid_c1", 32'(ia.dm_valid),  32'd1);
    chk("t3_stall_c1", 32'(ia.stall_mem), 32'd0);
    ia.dm_req = 0; ia.dm_we = 0;
    cyc(); @(negedge clk);
    chk("t3_en_c2",    32'(ia.mem_en),    32'd0);
    chk("t3_we_c2",    32'(ia.mem_we),    32'd0);
    chk("t3_valid_c2", 32'(ia.dm_valid),  32'd0);
    chk("t3_hold_c2",  ia.mem_addr,       32'h200);
    cyc();

    // ---------------- 2: simultaneous IF and DM load ----------------
    ia.if_req = 1; ia.if_addr = 32'h44;
    ia.dm_req = 1; ia.dm_we = 0; ia.dm_be = 4'hF; ia.dm_addr = 32'h100;
    @(negedge clk);
    chk("t2_stif_c0",  32'(ia.stall_if),  32'd1);
    chk("t2_stmem_c0", 32'(ia.stall_mem), 32'd1);
    cyc(); @(negedge clk);
    chk("t2_en_c1",    32'(ia.mem_en),    32'd1);
    chk("t2_addr_c1",  ia.mem_addr,       32'h100);
    cyc(); ia.mem_rdata = 32'hDEAD0001; @(negedge clk);
    cyc(); @(negedge clk);
    chk("t2_dmv_c3",   32'(ia.dm_valid),  32'd1);
    chk("t2_dmd_c3",   ia.dm_rdata,       32'hDEAD0001);
    chk("t2_ifv_c3",   32'(ia.if_valid),  32'd0);
    chk("t2_stif_c3",  32'(ia.stall_if),  32'd1);
    ia.dm_req = 0;
    cyc(); @(negedge clk);
    chk("t2_en_c4",    32'(ia.mem_en),    32'd0);
    cyc(); @(negedge clk);
    chk("t2_en_c5",    32'(ia.mem_en),    32'd1);
    chk("t2_addr_c5",  ia.mem_addr,       32'h44);
    cyc(); ia.mem_rdata = 32'h11112222; @(negedge clk);
    chk("t2_stif_c6",  32'(ia.stall_if),  32'd1);
    cyc(); @(negedge clk);
    chk("t2_ifv_c7",   32'(ia.if_valid),  32'd1);
    chk("t2_ifd_c7",   ia.if_rdata,       32'h11112222);
    chk("t2_dmv_c7",   32'(ia.dm_valid),  32'd0);
    chk("t2_stif_c7",  32'(ia.stall_if),  32'd0);
    ia.if_req = 0;
    cyc();

    // ---------------- 4: starvation guard ----------------
    ia.dm_req = 1; ia.dm_we = 0; ia.dm_addr = 32'h300;
    ia.if_req = 1; ia.if_addr = 32'h48; ia.mem_rdata = 32'hA5A50000;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 1 || k == 5 || k == 9 || k == 13 || k == 21)
        chk("t4_dm_grant", ia.mem_addr, 32'h300);
      if (k == 3 || k == 7 || k == 11 || k == 15 || k == 23) begin
        chk("t4_dm_valid", 32'(ia.dm_valid), 32'd1);
        chk("t4_if_quiet", 32'(ia.if_valid), 32'd0);
      end
      if (k == 17) chk("t4_if_forced", ia.mem_addr, 32'h48);
      if (k == 19) begin
        chk("t4_if_valid", 32'(ia.if_valid), 32'd1);
        chk("t4_dm_quiet", 32'(ia.dm_valid), 32'd0);
      end
      if (k == 23) begin
        ia.dm_req = 0;
        ia.if_req = 0;
      end
      cyc();
    end

    // ---------------- 5: reset during WAIT ----------------
    ia.if_req = 1; ia.if_addr = 32'h50;
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    ia.if_req = 0;
    #1;
    chk("t5_en_rst",    32'(ia.mem_en),   32'd0);
    chk("t5_valid_rst", 32'(ia.if_valid), 32'd0);
    chk("t5_addr_rst",  ia.mem_addr,      32'd0);
    chk("t5_be_rst",    32'(ia.mem_be),   32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    n_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ia.if_valid || ia.dm_valid || ia.mem_en) n_cnt++;
      cyc();
    end
    chk("t5_no_activity", 32'(n_cnt), 32'd0);
    ia.if_req = 1; ia.if_addr = 32'h54; ia.mem_rdata = 32'h2402002A;
    cyc(); @(negedge clk);
    chk("t5_en_c1",    32'(ia.mem_en),   32'd1);
    chk("t5_addr_c1",  ia.mem_addr,      32'h54);
    cyc(); cyc(); @(negedge clk);
    chk("t5_valid_c3", 32'(ia.if_valid), 32'd1);
    chk("t5_rdata_c3", ia.if_rdata,      32'h2402002A);
    ia.if_req = 0;
    cyc();

    // ---------------- 6a: MEM_LAT=4, IF drops req in WAIT ----------------
    ic.if_req = 1; ic.if_addr = 32'h20; ic.mem_rdata = 32'h0BADF00D;
    n_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ic.mem_en) n_cnt++;
      if (ic.mem_we) n_cnt += 100;
      chk("t6_l4_valid", 32'(ic.if_valid), 32'(k == 5));
      if (k == 1) chk("t6_l4_addr", ic.mem_addr, 32'h20);
      if (k == 5) chk("t6_l4_rdata", ic.if_rdata, 32'h0BADF00D);
      if (k == 2) ic.if_req = 0;
      cyc();
    end
    chk("t6_l4_en_count", 32'(n_cnt), 32'd1);

    // ---------------- 6b: MEM_LAT=1, DM byte load drops req in ISSUE ----------------
    ib.dm_req = 1; ib.dm_we = 0; ib.dm_be = 4'b0010;
    ib.dm_addr = 32'h10; ib.mem_rdata = 32'h0000AB00;
    n_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ib.mem_en) n_cnt++;
      chk("t6_l1_valid", 32'(ib.dm_valid), 32'(k == 2));
      if (k == 1) begin
        chk("t6_l1_be", 32'(ib.mem_be), 32'h2);
        ib.dm_req = 0;
      end
      if (k == 2) chk("t6_l1_rdata", ib.dm_rdata, 32'h0000AB00);
      cyc();
    end
    chk("t6_l1_en_count", 32'(n_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
